if_id_skid_reg: RTL and testbench

- Consumer end of the instruction-fetch interface: accepts {pc, instruction} from the fetch stage and presents it to decode.
- Two-entry skid buffer (head + skid registers) replacing a plain IF/ID register.
- Generates the fetch-side stall (fetch freeze = ~in_ready) from decode back-pressure, with no combinational path from decode to fetch.
- Flushes on a taken branch.

---
 rtl/if_id_skid_reg.sv | 130 +++++++++++++
 tb/tb_if_id_skid_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// ----------------------------------------------------------------------------
// if_id_skid_reg
// Two-entry skid buffer sitting between instruction fetch and decode. It
// replaces a plain IF/ID register so that decode back-pressure reaches fetch
// only through a flop (in_ready) and never through a combinational path.
// A taken branch (flush) empties the buffer and discards the word on the input.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      taken-branch flush, overrides accept/emit
//   in_valid   fetch presents {in_pc, in_inst}
//   in_pc      fetch PC (already +4)
//   in_inst    fetched instruction
//   in_ready   registered; buffer can accept (fetch freeze = ~in_ready)
//   out_valid  head entry valid for decode
//   out_pc     head PC (0 when out_valid=0)
//   out_inst   head instruction (NOP_INST when out_valid=0)
//   out_ready  decode consumes the head this cycle
//   occupancy  entries held, 0..2
// ----------------------------------------------------------------------------
module if_id_skid_reg #(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     NOP_INST = WIDTH'(0)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_inst,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_inst,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_head_pc;
  logic [WIDTH-1:0] r_head_inst;
  logic [WIDTH-1:0] r_skid_pc;
  logic [WIDTH-1:0] r_skid_inst;

  logic w_accept;
  logic w_emit;

  assign w_accept = in_valid & r_in_ready;
  assign w_emit   = r_out_valid & out_ready;

  // Single-process FSM; head registers are cleared to the bubble value
  // whenever the buffer empties so out_pc/out_inst need no output mux.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_head_pc   <= '0;
      r_head_inst <= NOP_INST;
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_head_pc   <= '0;
      r_head_inst <= NOP_INST;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
            r_head_pc   <= in_pc;
            r_head_inst <= in_inst;
          end
        end
        S_ONE: begin
          if (w_accept && !w_emit) begin
            // Decode stalled: park the new word and freeze fetch.
            r_state     <= S_FULL;
            r_skid_pc   <= in_pc;
            r_skid_inst <= in_inst;
            r_in_ready  <= 1'b0;
          end else if (w_emit && !w_accept) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_head_pc   <= '0;
            r_head_inst <= NOP_INST;
          end else if (w_accept && w_emit) begin
            r_head_pc   <= in_pc;
            r_head_inst <= in_inst;
          end
        end
        S_FULL: begin
          if (w_emit) begin
            r_state     <= S_ONE;
            r_head_pc   <= r_skid_pc;
            r_head_inst <= r_skid_inst;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_head_pc   <= '0;
          r_head_inst <= NOP_INST;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_pc    = r_head_pc;
  assign out_inst  = r_head_inst;
  assign occupancy = r_state;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// ----------------------------------------------------------------------------
// tb_if_id_skid_reg
// Table-driven directed vectors, hand-written async-reset sequence, then
// randomized traffic checked against a queue-based model of a 2-deep FIFO.
// ----------------------------------------------------------------------------
module tb_if_id_skid_reg;

  localparam int unsigned W   = 32;
  localparam logic [W-1:0] NOP = 32'h0000_0013;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_pc;
  logic [W-1:0] in_inst;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_pc;
  logic [W-1:0] out_inst;
  logic         out_ready;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;

  if_id_skid_reg #(.WIDTH(W), .NOP_INST(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] inst_of(input logic [W-1:0] pc);
    return {pc[15:0], 16'hC0DE} ^ 32'h1234_0000;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [W-1:0] epc,
                         input logic erdy, input logic [1:0] eocc);
    chk({tag, " out_valid"}, W'(out_valid), W'(ev));
    chk({tag, " out_pc"},    out_pc, ev ? epc : '0);
    chk({tag, " out_inst"},  out_inst, ev ? inst_of(epc) : NOP);
    chk({tag, " in_ready"},  W'(in_ready), W'(erdy));
    chk({tag, " occupancy"}, W'(occupancy), W'(eocc));
  endtask

  task automatic drive(input logic f, input logic iv, input logic [W-1:0] pc, input logic ordy);
    flush     = f;
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst_of(pc);
    out_ready = ordy;
  endtask

  // Advance one clock; outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         f;
    logic         iv;
    logic [W-1:0] pc;
    logic         ordy;
    logic         ev;
    logic [W-1:0] epc;
    logic         erdy;
    logic [1:0]   eocc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic f, input logic iv, input logic [W-1:0] pc,
                              input logic ordy, input logic ev, input logic [W-1:0] epc,
                              input logic erdy, input logic [1:0] eocc);
    vec_t v;
    v.f = f; v.iv = iv; v.pc = pc; v.ordy = ordy;
    v.ev = ev; v.epc = epc; v.erdy = erdy; v.eocc = eocc;
    return v;
  endfunction

  // Reference model: a bounded FIFO described by the buffer's rules.
  logic [W-1:0] mq_pc[$];
  logic [W-1:0] mq_inst[$];

  task automatic model_edge(input logic f, input logic iv, input logic [W-1:0] pc,
                            input logic [W-1:0] inst, input logic ordy);
    bit can_take = (mq_pc.size() < 2);
    bit pop      = (mq_pc.size() > 0) && ordy;
    bit push     = iv && can_take;
    if (f) begin
      mq_pc.delete();
      mq_inst.delete();
    end else begin
      if (pop) begin
        void'(mq_pc.pop_front());
        void'(mq_inst.pop_front());
      end
      if (push) begin
        mq_pc.push_back(pc);
        mq_inst.push_back(inst);
      end
    end
  endtask

  task automatic model_check();
    bit v = mq_pc.size() > 0;
    chk("rnd out_valid", W'(out_valid), W'(v));
    chk("rnd out_pc",    out_pc,   v ? mq_pc[0]   : '0);
    chk("rnd out_inst",  out_inst, v ? mq_inst[0] : NOP);
    chk("rnd in_ready",  W'(in_ready), W'(mq_pc.size() < 2));
    chk("rnd occupancy", W'(occupancy), W'(mq_pc.size()));
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    #12;
    chk_all("reset", 1'b0, '0, 1'b1, 2'd0);
    rst = 1'b1;
    #1;

    // Streaming
    vecs.push_back(mk(0, 1,  4, 1, 1,  4, 1, 1));
    vecs.push_back(mk(0, 1,  8, 1, 1,  8, 1, 1));
    vecs.push_back(mk(0, 1, 12, 1, 1, 12, 1, 1));
    vecs.push_back(mk(0, 1, 16, 1, 1, 16, 1, 1));
    vecs.push_back(mk(0, 0,  0, 1, 0,  0, 1, 0));
    // Back-pressure fill, then drain
    vecs.push_back(mk(0, 1,  4, 0, 1,  4, 1, 1));
    vecs.push_back(mk(0, 1,  8, 0, 1,  4, 0, 2));
    vecs.push_back(mk(0, 1, 12, 0, 1,  4, 0, 2));
    vecs.push_back(mk(0, 1, 12, 1, 1,  8, 1, 1));
    vecs.push_back(mk(0, 1, 12, 1, 1, 12, 1, 1));
    vecs.push_back(mk(0, 0,  0, 1, 0,  0, 1, 0));
    // Flush while full; word on the input in the flush cycle is dropped
    vecs.push_back(mk(0, 1,  4, 0, 1,  4, 1, 1));
    vecs.push_back(mk(0, 1,  8, 0, 1,  4, 0, 2));
    vecs.push_back(mk(1, 1, 20, 0, 0,  0, 1, 0));
    vecs.push_back(mk(0, 0, 20, 1, 0,  0, 1, 0));
    // Branch refill
    vecs.push_back(mk(1, 1, 50, 1, 0,  0, 1, 0));
    vecs.push_back(mk(0, 1,100, 0, 1,100, 1, 1));
    // Flush with emit in ONE
    vecs.push_back(mk(1, 0,  0, 1, 0,  0, 1, 0));
    vecs.push_back(mk(0, 0,  0, 1, 0,  0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].f, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].erdy, vecs[i].eocc);
    end

    // Async reset mid-operation: fill, then pulse rst between edges
    drive(0, 1, 32'd300, 0); step();
    drive(0, 1, 32'd304, 0); step();
    chk_all("prefill", 1'b1, 32'd300, 1'b0, 2'd2);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, '0, 1'b1, 2'd0);
    drive(0, 0, '0, 0);
    #4;
    rst = 1'b1;
    drive(0, 1, 32'd200, 0);
    step();
    chk_all("post_rst", 1'b1, 32'd200, 1'b1, 2'd1);

    // Randomized traffic against the model, starting from a flush
    drive(1, 0, '0, 0);
    step();
    mq_pc.delete();
    mq_inst.delete();
    model_check();
    for (int c = 0; c < 600; c++) begin
      logic         f, iv, ordy;
      logic [W-1:0] pc, inst;
      f    = ($urandom_range(0, 15) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      pc   = W'($urandom);
      inst = W'($urandom);
      flush = f; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
      model_edge(f, iv, pc, inst, ordy);
      step();
      model_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
